ccl_window_gen: RTL

Upstream feeder for the connected-components labeling stage. It accepts a raster pixel stream and presents each pixel with its causal neighbourhood labels: A (up-left), B (up), C (up-right) and D (left), plus x and y. A one-line label buffer holds the previous row. The labeling stage returns the label it assigns (q), and that label is written back so the window for the next pixel and the next row is correct.

---
 rtl/ccl_window_gen_if.sv | 45 ++++
 rtl/ccl_window_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ccl_window_gen_if.sv
// -----------------------------------------------------------------------------
// ccl_window_gen_if
//   Bus bundle between the raster pixel source / labeling stage (master side)
//   and the ccl_window_gen neighbourhood builder (slave side).
//
//   Pixel input    : in_valid, in_ready, in_sof, in_pixel
//   Window output  : out_valid, A, B, C, D, p, x, y
//   Label return   : label_valid, label_in
//   Status         : frame_done
//
//   Handshake: a pixel transfers on a rising clk edge where in_valid and
//   in_ready are both 1; in_sof/in_pixel are only meaningful while in_valid
//   is 1. out_valid is a single-cycle strobe with no back-pressure, and
//   label_valid is a single-cycle strobe accepted only while a window is
//   outstanding (in_ready = 0); it is ignored otherwise.
// -----------------------------------------------------------------------------
interface ccl_window_gen_if #(
   parameter int WORD_SIZE = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_sof;
   logic [WORD_SIZE-1:0] in_pixel;
   logic                 out_valid;
   logic [WORD_SIZE-1:0] A;
   logic [WORD_SIZE-1:0] B;
   logic [WORD_SIZE-1:0] C;
   logic [WORD_SIZE-1:0] D;
   logic [WORD_SIZE-1:0] p;
   logic [31:0]          x;
   logic [31:0]          y;
   logic                 label_valid;
   logic [WORD_SIZE-1:0] label_in;
   logic                 frame_done;

   modport master (
      output in_valid, in_sof, in_pixel, label_valid, label_in,
      input  in_ready, out_valid, A, B, C, D, p, x, y, frame_done
   );

   modport slave (
      input  in_valid, in_sof, in_pixel, label_valid, label_in,
      output in_ready, out_valid, A, B, C, D, p, x, y, frame_done
   );
endinterface

// File: rtl/ccl_window_gen.sv
// -----------------------------------------------------------------------------
// ccl_window_gen
//   Builds the causal 2x3 neighbourhood (A up-left, B up, C up-right, D left)
//   for each raster pixel ahead of the connected-components labeling stage.
//   A one-row label buffer keeps the previous row; the label the labeling
//   stage assigns is written back so later windows see it.
//
// Ports
//   clk        : clock
//   reset_n    : synchronous, active-low reset
//   bus        : ccl_window_gen_if.slave (pixel in, window out, label return,
//                frame_done)
//   dbg_state  : current FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module ccl_window_gen #(
   parameter int WORD_SIZE  = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic              clk,
   input  logic              reset_n,
   ccl_window_gen_if.slave   bus,
   output logic [0:0]        dbg_state
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   // Position of the next pixel to be accepted.
   logic [XW-1:0]        col_q, col_d;
   logic [YW-1:0]        row_q, row_d;
   // Position of the pixel whose window is currently presented.
   logic [XW-1:0]        acc_col_q, acc_col_d;
   logic [YW-1:0]        acc_row_q, acc_row_d;
   logic [WORD_SIZE-1:0] a_q, a_d;
   logic [WORD_SIZE-1:0] b_q, b_d;
   logic [WORD_SIZE-1:0] c_q, c_d;
   logic [WORD_SIZE-1:0] d_q, d_d;
   logic [WORD_SIZE-1:0] p_q, p_d;
   logic [WORD_SIZE-1:0] left_q, left_d;
   logic                 out_valid_q, out_valid_d;
   logic                 frame_done_q, frame_done_d;

   // Previous-row labels, one entry per column. Never cleared: row 0 is
   // masked, so stale contents are never visible.
   logic [WORD_SIZE-1:0] line_mem [IMG_WIDTH];

   logic                 wr_en;
   logic [XW-1:0]        cur_col;
   logic [YW-1:0]        cur_row;
   logic [XW-1:0]        c_addr;
   logic [WORD_SIZE-1:0] rd_b;
   logic [WORD_SIZE-1:0] rd_c;
   logic                 col_zero;
   logic                 row_zero;
   logic                 col_last;

   // -------------------------------------------------------------------------
   // Next-state / datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      acc_col_d    = acc_col_q;
      acc_row_d    = acc_row_q;
      a_d          = a_q;
      b_d          = b_q;
      c_d          = c_q;
      d_d          = d_q;
      p_d          = p_q;
      left_d       = left_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      wr_en        = 1'b0;

      // Start-of-frame overrides wherever the counters happen to be.
      cur_col  = bus.in_sof ? '0 : col_q;
      cur_row  = bus.in_sof ? '0 : row_q;
      col_zero = (cur_col == '0);
      row_zero = (cur_row == '0);
      col_last = (cur_col == X_LAST);

      // At the right edge the up-right entry does not exist; point the read
      // at a legal address and mask the result below.
      c_addr   = col_last ? '0 : cur_col + XW'(1);
      rd_b     = line_mem[cur_col];
      rd_c     = line_mem[c_addr];

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d     = S_WAIT;
               out_valid_d = 1'b1;
               p_d         = bus.in_pixel;
               acc_col_d   = cur_col;
               acc_row_d   = cur_row;
               // Within a row the window slides right: the old B becomes A and
               // the old C becomes B. Column x-1 of the buffer already holds
               // the current row's label, so A can only come from the shift.
               // At column 0 there is no history, so B is read directly.
               a_d = (col_zero || row_zero) ? '0 : b_q;
               b_d = row_zero ? '0 : (col_zero ? rd_b : c_q);
               c_d = (row_zero || col_last) ? '0 : rd_c;
               d_d = col_zero ? '0 : left_q;
            end
         end

         S_WAIT: begin
            if (bus.label_valid) begin
               state_d = S_IDLE;
               wr_en   = 1'b1;
               left_d  = bus.label_in;
               if (acc_col_q == X_LAST) begin
                  col_d = '0;
                  if (acc_row_q == Y_LAST) begin
                     row_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     row_d = acc_row_q + YW'(1);
                  end
               end else begin
                  col_d = acc_col_q + XW'(1);
                  row_d = acc_row_q;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         acc_col_q    <= '0;
         acc_row_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         c_q          <= '0;
         d_q          <= '0;
         p_q          <= '0;
         left_q       <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         acc_col_q    <= acc_col_d;
         acc_row_q    <= acc_row_d;
         a_q          <= a_d;
         b_q          <= b_d;
         c_q          <= c_d;
         d_q          <= d_d;
         p_q          <= p_d;
         left_q       <= left_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Label write-back; a label arriving during reset is dropped.
   always_ff @(posedge clk) begin
      if (reset_n && wr_en) begin
         line_mem[acc_col_q] <= bus.label_in;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.A          = a_q;
   assign bus.B          = b_q;
   assign bus.C          = c_q;
   assign bus.D          = d_q;
   assign bus.p          = p_q;
   assign bus.x          = {{(32-XW){1'b0}}, acc_col_q};
   assign bus.y          = {{(32-YW){1'b0}}, acc_row_q};
   assign dbg_state      = state_q;

endmodule
